// File: rtl/burst_scheduler_if.sv
// rtl/burst_scheduler_if.sv - request/burst bundle between requesters and the burst scheduler
//
// Purpose: groups the per-requester request/length inputs and the burst
// outputs of burst_scheduler into one bundle.
//
// Signals:
//   req       requester -> scheduler  level request per requester
//   req_len   requester -> scheduler  packed length fields, burst = field + 1
//   grant     scheduler -> requester  one-hot owner of the current burst
//   out       scheduler -> consumer   burst strobe, high on every beat
//   burst_id  scheduler -> consumer   index of the current/last owner
//   beat_cnt  scheduler -> consumer   0-based beat index within the burst
//   busy      scheduler -> consumer   high whenever the scheduler is not idle
//   done      scheduler -> requester  one-cycle pulse after the last beat
//
// Modports: slave = scheduler side, master = requester side.

interface burst_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       grant;
    logic                     out;
    logic [IDW-1:0]           burst_id;
    logic [LEN_W-1:0]         beat_cnt;
    logic                     busy;
    logic [NUM_REQ-1:0]       done;

    modport slave (
        input  req,
        input  req_len,
        output grant,
        output out,
        output burst_id,
        output beat_cnt,
        output busy,
        output done
    );

    modport master (
        output req,
        output req_len,
        input  grant,
        input  out,
        input  burst_id,
        input  beat_cnt,
        input  busy,
        input  done
    );
endinterface

// File: rtl/burst_scheduler.sv
// rtl/burst_scheduler.sv - round-robin scheduler sharing one pulse-burst generator
//
// Purpose: arbitrates NUM_REQ requesters round-robin; the winner gets one
// burst of 1..2^LEN_W strobe beats followed by GAP idle cycles, then a
// one-cycle done pulse marks completion. All outputs are registered.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of burst_scheduler_if
//         (req, req_len in; grant, out, burst_id, beat_cnt, busy, done out)
//
// Parameters:
//   NUM_REQ  number of requesters, 2..8
//   LEN_W    width of each length field
//   GAP      idle cycles after each burst, 1..15

module burst_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4,
    parameter int GAP     = 1
) (
    input  logic               clk,
    input  logic               rst,
    burst_scheduler_if.slave   bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]         r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [LEN_W-1:0]   r_len_q;
    logic [LEN_W-1:0]   r_beat_cnt;
    logic [3:0]         r_gap_cnt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic [IDW-1:0]     r_burst_id;
    logic               r_out;
    logic               r_busy;

    logic               w_found;
    logic [IDW-1:0]     w_winner;
    logic [IDW:0]       w_idx;
    logic [IDW-1:0]     w_next_ptr;
    logic [NUM_REQ-1:0] w_onehot;
    logic [LEN_W-1:0]   w_len;

    // Round-robin search: walk from r_rr_ptr upward, wrapping modulo
    // NUM_REQ, and keep the first requester found. w_idx carries one extra
    // bit so the pre-wrap sum never overflows.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NUM_REQ)) begin
                w_idx = w_idx - (IDW+1)'(NUM_REQ);
            end
            if (!w_found && bus.req[w_idx[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[IDW-1:0];
            end
        end
    end

    // Length field of the winner, selected with constant part-selects.
    always_comb begin
        w_len = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_winner == IDW'(k)) begin
                w_len = bus.req_len[k*LEN_W +: LEN_W];
            end
        end
    end

    assign w_onehot   = NUM_REQ'(1) << w_winner;
    assign w_next_ptr = (w_winner == IDW'(NUM_REQ-1)) ? '0 : (w_winner + IDW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_len_q    <= '0;
            r_beat_cnt <= '0;
            r_gap_cnt  <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_burst_id <= '0;
            r_out      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    // req/req_len are only looked at here, so anything the
                    // requesters do during BURST/GAP is ignored.
                    if (w_found) begin
                        r_state    <= ST_BURST;
                        r_grant    <= w_onehot;
                        r_burst_id <= w_winner;
                        r_len_q    <= w_len;
                        r_beat_cnt <= '0;
                        r_out      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_rr_ptr   <= w_next_ptr;
                    end
                end
                ST_BURST: begin
                    if (r_beat_cnt == r_len_q) begin
                        // r_grant is still the owner's one-hot, which is
                        // exactly the done bit to raise.
                        r_done     <= r_grant;
                        r_grant    <= '0;
                        r_out      <= 1'b0;
                        r_beat_cnt <= '0;
                        r_gap_cnt  <= 4'(GAP - 1);
                        r_state    <= ST_GAP;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_grant    <= '0;
                    r_out      <= 1'b0;
                    r_beat_cnt <= '0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant    = r_grant;
    assign bus.out      = r_out;
    assign bus.burst_id = r_burst_id;
    assign bus.beat_cnt = r_beat_cnt;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule

// File: tb/tb_burst_scheduler.sv
// tb/tb_burst_scheduler.sv - self-checking bench for burst_scheduler

module tb_burst_scheduler;

    logic clk;
    logic rst;

    burst_scheduler_if #(.NUM_REQ(4), .LEN_W(4)) bus ();
    burst_scheduler_if #(.NUM_REQ(4), .LEN_W(4)) b3 ();

    burst_scheduler #(.NUM_REQ(4), .LEN_W(4), .GAP(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    burst_scheduler #(.NUM_REQ(4), .LEN_W(4), .GAP(3)) u_dut_gap3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    typedef struct {
        int idx;
        int beat;
    } beat_t;

    beat_t beat_q[$];
    int    done_q[$];
    beat_t mon_e;
    int    mon_d;
    bit    mon_en;

    int n_assert;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input int idx, input int nbeats, input bit with_done);
        beat_t e;
        for (int b = 0; b < nbeats; b++) begin
            e.idx  = idx;
            e.beat = b;
            beat_q.push_back(e);
        end
        if (with_done) done_q.push_back(idx);
    endtask

    // Scoreboard monitor for the GAP=1 instance: every beat and every done
    // pulse must match the next expected entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out === 1'b1) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", 32'(bus.beat_cnt), 32'hFFFF_FFFF);
                end else begin
                    mon_e = beat_q.pop_front();
                    check("sb_grant", 32'(bus.grant), 32'(1) << mon_e.idx);
                    check("sb_burst_id", 32'(bus.burst_id), 32'(mon_e.idx));
                    check("sb_beat_cnt", 32'(bus.beat_cnt), 32'(mon_e.beat));
                end
            end
            if (bus.done !== 4'b0000) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 32'h0);
                end else begin
                    mon_d = done_q.pop_front();
                    check("sb_done", 32'(bus.done), 32'(1) << mon_d);
                end
            end
        end
    end

    initial begin
        int times[$];
        int beats;

        n_assert = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.req_len = '0;
        b3.req   = '0;
        b3.req_len = '0;

        // Reset state
        tick();
        tick();
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_out", 32'(bus.out), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_beat_cnt", 32'(bus.beat_cnt), 32'h0);
        check("rst_burst_id", 32'(bus.burst_id), 32'h0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single 16-beat burst from requester 0
        bus.req_len[3:0] = 4'd15;
        bus.req          = 4'b0001;
        push_burst(0, 16, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("t1_out", 32'(bus.out), 32'h1);
            check("t1_grant", 32'(bus.grant), 32'h1);
            check("t1_beat_cnt", 32'(bus.beat_cnt), 32'(c - 1));
            check("t1_busy", 32'(bus.busy), 32'h1);
        end
        tick();
        check("t1_done", 32'(bus.done), 32'h1);
        check("t1_out_low", 32'(bus.out), 32'h0);
        check("t1_busy_gap", 32'(bus.busy), 32'h1);
        bus.req = 4'b0000;
        tick();
        check("t1_busy_fall", 32'(bus.busy), 32'h0);
        check("t1_done_pulse", 32'(bus.done), 32'h0);

        // Round-robin fairness, all requesters, length 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_len = '0;
        bus.req     = 4'b1111;
        push_burst(0, 1, 1'b1);
        push_burst(1, 1, 1'b1);
        push_burst(2, 1, 1'b1);
        push_burst(3, 1, 1'b1);
        push_burst(0, 1, 1'b1);
        push_burst(1, 1, 1'b1);
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (bus.out === 1'b1) times.push_back(c);
        end
        bus.req = 4'b0000;
        tick();
        check("rr_pulse_count", 32'(times.size()), 32'd6);
        if (times.size() > 0) check("rr_first_pulse", 32'(times[0]), 32'd1);
        for (int i = 1; i < times.size(); i++) begin
            check("rr_period", 32'(times[i] - times[i-1]), 32'd3);
        end

        // Pointer wrap: grant 3, then 1001 must go to 0
        tick();
        bus.req = 4'b1000;
        push_burst(3, 1, 1'b1);
        push_burst(0, 1, 1'b1);
        tick();
        check("wrap_grant3", 32'(bus.grant), 32'h8);
        bus.req = 4'b1001;
        tick();
        tick();
        tick();
        check("wrap_grant0", 32'(bus.grant), 32'h1);
        bus.req = 4'b0000;
        tick();
        tick();
        tick();
        check("wrap_idle", 32'(bus.busy), 32'h0);

        // Mid-burst req drop and length change are ignored
        bus.req_len[7:4] = 4'd7;
        bus.req          = 4'b0010;
        push_burst(1, 8, 1'b1);
        beats = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.out === 1'b1) beats++;
            if (c == 2) begin
                bus.req     = 4'b0000;
                bus.req_len = 16'h2222;
            end
            if (c == 9) check("mid_done", 32'(bus.done), 32'h2);
        end
        check("mid_beats", 32'(beats), 32'd8);
        check("mid_no_regrant", 32'(bus.busy), 32'h0);

        // Reset at beat 5, then a fresh request from requester 2
        bus.req_len[11:8] = 4'd9;
        bus.req           = 4'b0100;
        push_burst(2, 6, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            tick();
        end
        check("rstm_beat5", 32'(bus.beat_cnt), 32'd5);
        rst = 1'b1;
        tick();
        check("rstm_grant", 32'(bus.grant), 32'h0);
        check("rstm_out", 32'(bus.out), 32'h0);
        check("rstm_busy", 32'(bus.busy), 32'h0);
        check("rstm_done", 32'(bus.done), 32'h0);
        check("rstm_beat_cnt", 32'(bus.beat_cnt), 32'h0);
        check("rstm_burst_id", 32'(bus.burst_id), 32'h0);
        rst = 1'b0;
        bus.req_len[11:8] = 4'd1;
        push_burst(2, 2, 1'b1);
        tick();
        check("rstm_regrant", 32'(bus.grant), 32'h4);
        check("rstm_beat0", 32'(bus.beat_cnt), 32'h0);
        check("rstm_out_hi", 32'(bus.out), 32'h1);
        bus.req = 4'b0000;
        tick();
        tick();
        tick();
        tick();
        check("rstm_idle", 32'(bus.busy), 32'h0);

        // GAP=3 instance: back-to-back length-0 bursts every 5 cycles
        b3.req = 4'b0001;
        for (int c = 1; c <= 14; c++) begin
            tick();
            check("g3_out", 32'(b3.out), (c % 5 == 1) ? 32'h1 : 32'h0);
            check("g3_busy", 32'(b3.busy), (c % 5 != 0) ? 32'h1 : 32'h0);
            check("g3_done", 32'(b3.done), (c % 5 == 2) ? 32'h1 : 32'h0);
        end
        b3.req = 4'b0000;
        tick();
        tick();
        tick();
        check("g3_idle", 32'(b3.busy), 32'h0);

        check("sb_beats_left", 32'(beat_q.size()), 32'd0);
        check("sb_done_left", 32'(done_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
